// File: rtl/z_writeback_stage_pkg.sv
// ============================================================================
// Module      : z_writeback_stage_pkg
// Description : Shared opcode constants, bus destination codes and FSM states
//               for the Z writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package z_writeback_stage_pkg;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_MUL = 5'b10000;

    localparam logic [1:0] DEST_RZ = 2'd0;
    localparam logic [1:0] DEST_LO = 2'd1;
    localparam logic [1:0] DEST_HI = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER_RZ = 2'd1,
        ST_XFER_LO = 2'd2,
        ST_XFER_HI = 2'd3
    } state_t;

    function automatic logic is_two_word(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/z_hold_reg.sv
// ============================================================================
// Module      : z_hold_reg
// Description : Clear/enable register pair holding the ALU result as ZHi/ZLo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module z_hold_reg #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en_i,
    input  logic [2*DATA_W-1:0] d_i,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (en_i) begin
            hi_q <= d_i[2*DATA_W-1:DATA_W];
            lo_q <= d_i[DATA_W-1:0];
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

`default_nettype wire

// File: rtl/z_writeback_stage.sv
// ============================================================================
// Module      : z_writeback_stage
// Description : Captures the 64-bit ALU result into ZHi/ZLo and drains it onto
//               the bus as one (Rz) or two (LO, HI) valid/ready transfers.
//               Optional result flags enabled by defining Z_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module z_writeback_stage
    import z_writeback_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [2*DATA_W-1:0] alu_c,
    input  logic [4:0]          opcode,
    input  logic                z_in,
    output logic                z_ready,
    output logic [DATA_W-1:0]   zhi_out,
    output logic [DATA_W-1:0]   zlo_out,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [DATA_W-1:0]   bus_data,
    output logic [1:0]          bus_dest,
    output logic                flag_zero,
    output logic                flag_neg
);

    state_t            state_q, state_d;
    logic              is_div_q, is_div_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        dest_q, dest_d;
    logic              capture;
    logic [DATA_W-1:0] zhi, zlo;

    assign capture = z_in && (state_q == ST_IDLE);

    z_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk  (clk),
        .clr  (clr),
        .en_i (capture),
        .d_i  (alu_c),
        .hi_o (zhi),
        .lo_o (zlo)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            is_div_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            dest_q   <= DEST_RZ;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            dest_q   <= dest_d;
        end
    end

    // Output words are computed one cycle ahead so bus_data/bus_dest are registered.
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        valid_d  = valid_q;
        data_d   = data_q;
        dest_d   = dest_q;
        case (state_q)
            ST_IDLE: begin
                if (z_in) begin
                    valid_d  = 1'b1;
                    is_div_d = (opcode == OP_DIV);
                    if (is_two_word(opcode)) begin
                        state_d = ST_XFER_LO;
                        dest_d  = DEST_LO;
                        data_d  = (opcode == OP_DIV) ? alu_c[2*DATA_W-1:DATA_W]
                                                     : alu_c[DATA_W-1:0];
                    end else begin
                        state_d = ST_XFER_RZ;
                        dest_d  = DEST_RZ;
                        data_d  = alu_c[DATA_W-1:0];
                    end
                end
            end
            ST_XFER_RZ: begin
                if (bus_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            ST_XFER_LO: begin
                if (bus_ready) begin
                    state_d = ST_XFER_HI;
                    dest_d  = DEST_HI;
                    data_d  = is_div_q ? zlo : zhi;
                end
            end
            ST_XFER_HI: begin
                if (bus_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

`ifdef Z_FLAGS_EN
    logic zero_q, neg_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (capture) begin
            zero_q <= (alu_c[DATA_W-1:0] == '0);
            neg_q  <= alu_c[DATA_W-1];
        end
    end

    assign flag_zero = zero_q;
    assign flag_neg  = neg_q;
`else
    assign flag_zero = 1'b0;
    assign flag_neg  = 1'b0;
`endif

    assign z_ready   = (state_q == ST_IDLE);
    assign zhi_out   = zhi;
    assign zlo_out   = zlo;
    assign bus_valid = valid_q;
    assign bus_data  = data_q;
    assign bus_dest  = dest_q;

endmodule

`default_nettype wire

// File: tb/tb_z_writeback_stage.sv
// ============================================================================
// Module      : tb_z_writeback_stage
// Description : Directed, table-driven self-checking bench for z_writeback_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z_writeback_stage;

    logic        clk = 1'b0;
    logic        clr;
    logic [63:0] alu_c;
    logic [4:0]  opcode;
    logic        z_in;
    logic        z_ready;
    logic [31:0] zhi_out, zlo_out;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_data;
    logic [1:0]  bus_dest;
    logic        flag_zero, flag_neg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    z_writeback_stage #(.DATA_W(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .alu_c     (alu_c),
        .opcode    (opcode),
        .z_in      (z_in),
        .z_ready   (z_ready),
        .zhi_out   (zhi_out),
        .zlo_out   (zlo_out),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_data  (bus_data),
        .bus_dest  (bus_dest),
        .flag_zero (flag_zero),
        .flag_neg  (flag_neg)
    );

    typedef struct {
        logic [63:0] c;
        logic [4:0]  op;
        int          nwords;
        logic [31:0] d0;
        logic [1:0]  dst0;
        logic [31:0] d1;
        logic [1:0]  dst1;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flags are only live when the option is built in.
    task automatic chk_flags(input string name, input logic [31:0] lo);
`ifdef Z_FLAGS_EN
        chk({name, ".zero"}, {63'd0, flag_zero}, {63'd0, lo == 32'd0});
        chk({name, ".neg"},  {63'd0, flag_neg},  {63'd0, lo[31]});
`else
        chk({name, ".zero"}, {63'd0, flag_zero}, 64'd0);
        chk({name, ".neg"},  {63'd0, flag_neg},  64'd0);
`endif
    endtask

    task automatic capture(input logic [63:0] c, input logic [4:0] op);
        alu_c  = c;
        opcode = op;
        z_in   = 1'b1;
        tick();
        z_in   = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{64'h0000_0000_0000_0007, 5'b00011, 1, 32'h7,         2'd0, 32'h0,         2'd0};
        vecs[1] = '{64'h0000_0001_8000_0000, 5'b10000, 2, 32'h8000_0000, 2'd1, 32'h1,         2'd2};
        vecs[2] = '{64'h0000_0005_0000_0002, 5'b01111, 2, 32'h5,         2'd1, 32'h2,         2'd2};
        vecs[3] = '{64'hDEAD_BEEF_1234_5678, 5'b11111, 1, 32'h1234_5678, 2'd0, 32'h0,         2'd0};
        vecs[4] = '{64'hFFFF_FFFF_0000_0000, 5'b10000, 2, 32'h0,         2'd1, 32'hFFFF_FFFF, 2'd2};
        vecs[5] = '{64'h0000_0000_FFFF_FFFF, 5'b01111, 2, 32'h0,         2'd1, 32'hFFFF_FFFF, 2'd2};

        clr = 1'b1; alu_c = '0; opcode = '0; z_in = 1'b0; bus_ready = 1'b0;
        tick(); tick();
        clr = 1'b0;
        chk("rst.z_ready",   {63'd0, z_ready},   64'd1);
        chk("rst.bus_valid", {63'd0, bus_valid}, 64'd0);
        chk("rst.zhi",       {32'd0, zhi_out},   64'd0);
        chk("rst.zlo",       {32'd0, zlo_out},   64'd0);
        chk("rst.bus_data",  {32'd0, bus_data},  64'd0);
        chk("rst.bus_dest",  {62'd0, bus_dest},  64'd0);
        chk_flags("rst", 32'd0);

        // Table-driven: back-to-back transfers with bus_ready held high.
        bus_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            capture(vecs[i].c, vecs[i].op);
            chk($sformatf("v%0d.valid0", i), {63'd0, bus_valid}, 64'd1);
            chk($sformatf("v%0d.zready0", i), {63'd0, z_ready}, 64'd0);
            chk($sformatf("v%0d.data0", i), {32'd0, bus_data}, {32'd0, vecs[i].d0});
            chk($sformatf("v%0d.dest0", i), {62'd0, bus_dest}, {62'd0, vecs[i].dst0});
            chk($sformatf("v%0d.hold", i), {zhi_out, zlo_out}, vecs[i].c);
            chk_flags($sformatf("v%0d", i), vecs[i].c[31:0]);
            tick();
            if (vecs[i].nwords == 2) begin
                chk($sformatf("v%0d.valid1", i), {63'd0, bus_valid}, 64'd1);
                chk($sformatf("v%0d.data1", i), {32'd0, bus_data}, {32'd0, vecs[i].d1});
                chk($sformatf("v%0d.dest1", i), {62'd0, bus_dest}, {62'd0, vecs[i].dst1});
                tick();
            end
            chk($sformatf("v%0d.idle_valid", i), {63'd0, bus_valid}, 64'd0);
            chk($sformatf("v%0d.idle_zready", i), {63'd0, z_ready}, 64'd1);
        end

        // Multiply with backpressure: LO word held stable for 3 cycles.
        bus_ready = 1'b0;
        capture(64'h0000_0001_8000_0000, 5'b10000);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp.valid%0d", k), {63'd0, bus_valid}, 64'd1);
            chk($sformatf("bp.data%0d", k), {32'd0, bus_data}, 64'h8000_0000);
            chk($sformatf("bp.dest%0d", k), {62'd0, bus_dest}, 64'd1);
            if (k < 2) tick();
        end
        bus_ready = 1'b1;
        tick();
        chk("bp.hi_data", {32'd0, bus_data}, 64'h1);
        chk("bp.hi_dest", {62'd0, bus_dest}, 64'd2);
        tick();
        chk("bp.done", {63'd0, bus_valid}, 64'd0);

        // z_in while busy in XFER_LO is ignored.
        bus_ready = 1'b0;
        capture(64'h1111_2222_3333_4444, 5'b10000);
        alu_c = 64'hAAAA_BBBB_CCCC_DDDD; z_in = 1'b1;
        tick();
        z_in = 1'b0;
        chk("busy.hold", {zhi_out, zlo_out}, 64'h1111_2222_3333_4444);
        chk("busy.lo",   {32'd0, bus_data}, 64'h3333_4444);
        bus_ready = 1'b1;
        tick();
        chk("busy.hi",   {32'd0, bus_data}, 64'h1111_2222);
        tick();
        chk("busy.done", {63'd0, bus_valid}, 64'd0);

        // Transfer completing on the same edge as z_in: no capture.
        capture(64'h0000_0000_0000_0042, 5'b00011);
        alu_c = 64'h0000_0000_0000_0099; z_in = 1'b1;
        tick();
        z_in = 1'b0;
        chk("same.valid", {63'd0, bus_valid}, 64'd0);
        chk("same.zlo",   {32'd0, zlo_out},   64'h42);

        // clr while bus_valid high in XFER_HI.
        capture(64'h0000_0005_0000_0002, 5'b01111);
        tick();
        chk("clr.in_hi", {62'd0, bus_dest}, 64'd2);
        bus_ready = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr.valid",  {63'd0, bus_valid}, 64'd0);
        chk("clr.zready", {63'd0, z_ready},   64'd1);
        chk("clr.hold",   {zhi_out, zlo_out}, 64'd0);
        chk_flags("clr", 32'd0);

        // clr and z_in on the same edge: clr wins.
        alu_c = 64'h0000_0007_8000_0001; opcode = 5'b00011; z_in = 1'b1; clr = 1'b1;
        tick();
        z_in = 1'b0; clr = 1'b0;
        chk("clrz.valid", {63'd0, bus_valid}, 64'd0);
        chk("clrz.hold",  {zhi_out, zlo_out}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
